rr_arbiter_8: RTL and testbench

// - Round-robin request arbiter directly upstream of the 8-to-3 one-hot encoder.
// - Takes up to N concurrent request lines and produces a registered grant vector.
// - The grant is guaranteed to be all-zero or exactly one-hot, so the encoder's default case never fires on a two-hot input.
// - Grant is held until the owner releases it; priority then rotates past the last owner.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 38 +++
 rtl/rr_arbiter_8.sv | 133 +++++++++++++
 tb/tb_rr_arbiter_8.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the FSM state enum, default width and grant sanity check.
package arb_pkg;

  localparam int ARB_N = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_t;

  // True when vec is all-zero or exactly one-hot.
  function automatic logic onehot_ok(
    input logic [ARB_N-1:0] vec
  );
    return (vec & (vec - ARB_N'(1))) == '0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit at or above ptr.
// Ports: req/ptr in; onehot (selected bit), idx (its index), any (req!=0) out.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = ARB_N,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0]   rot;
  logic [N-1:0]   low;

  always_comb begin
    // Rotate right so ptr lands at bit 0, isolate the lowest set bit,
    // then rotate left by the same amount to restore positions.
    dbl    = {req, req} >> ptr;
    rot    = dbl[N-1:0];
    low    = rot & (~rot + ONE);
    back   = {low, low} << ptr;
    onehot = back[2*N-1:N];
    any    = |req;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter with registered all-zero/one-hot grant and a GAP cycle.
// Ports: CLK, RST (sync, high), REQ_I, DONE_I in; GNT_O, GNT_VLD_O, TIMEOUT_O out.
// Optional grant-hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ_I,
  input  logic         DONE_I,
  output logic [N-1:0] GNT_O,
  output logic         GNT_VLD_O,
  output logic         TIMEOUT_O
);

  localparam int W = $clog2(N);

  if (N < 2 || (1 << W) != N) begin : g_bad_n
    $error("N must be a power of two >= 2");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("MAX_HOLD must be >= 2");
  end

  arb_state_t   state, state_nxt;
  logic [N-1:0] gnt, gnt_nxt;
  logic [W-1:0] ptr, ptr_nxt;
  logic [W-1:0] owner, owner_nxt;
  logic         tmo, tmo_nxt;
  logic         rel_norm;
  logic         tmo_hit;

  logic [N-1:0] pick_oh;
  logic [W-1:0] pick_idx;
  logic         pick_any;

  rr_pick #(.N(N)) u_pick (
    .req    (REQ_I),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;

  logic [CW-1:0] cnt;

  // Zero outside GRANT, so each grant starts counting from 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (state != GRANT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tmo_hit = (state == GRANT) && (cnt == CW'(MAX_HOLD - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      owner <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      tmo   <= tmo_nxt;
    end
  end

  assign rel_norm = DONE_I | ~REQ_I[owner];

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    tmo_nxt   = 1'b0;
    unique case (state)
      IDLE, GAP: begin
        // GAP arbitrates on its exit edge, so the grant
        // register stays low for exactly one cycle.
        if (pick_any) begin
          state_nxt = GRANT;
          gnt_nxt   = pick_oh;
          owner_nxt = pick_idx;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (rel_norm || tmo_hit) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          ptr_nxt   = owner + W'(1);
          tmo_nxt   = tmo_hit & ~rel_norm;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    GNT_O     = gnt;
    GNT_VLD_O = |gnt;
    TIMEOUT_O = tmo;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (onehot_ok(ARB_N'(gnt)))
        else $error("grant not one-hot: %b", gnt);
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8.
// Define ARB_TIMEOUT_EN to also exercise the timeout path (MAX_HOLD=4).
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       vld;
  logic       tmo;

  int total = 0;
  int bad   = 0;

  rr_arbiter_8 #(.N(8), .MAX_HOLD(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ_I     (req),
    .DONE_I    (done),
    .GNT_O     (gnt),
    .GNT_VLD_O (vld),
    .TIMEOUT_O (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: got %02h want %02h", tag, obs, exp);
      end
  endtask

  // Per-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    total++;
    assert ($countones(gnt) <= 1)
      else begin
        bad++;
        $error("FAIL onehot: got %02h want <=1 bit", gnt);
      end
    total++;
    assert (vld === (gnt != 8'h00))
      else begin
        bad++;
        $error("FAIL vld: got %b want %b", vld, gnt != 8'h00);
      end
  end

  initial begin
    logic [7:0] e;
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;

    tick();
    chk("rst_gnt0", gnt, 8'h00);
    chk("rst_vld0", {7'b0, vld}, 8'h00);
    chk("rst_tmo0", {7'b0, tmo}, 8'h00);
    tick();
    chk("rst_gnt1", gnt, 8'h00);
    rst = 1'b0;
    tick();
    chk("first_gnt", gnt, 8'h01);
    chk("first_vld", {7'b0, vld}, 8'h01);

    for (int i = 1; i <= 8; i++) begin
      done = 1'b1;
      tick();
      chk("rot_gap", gnt, 8'h00);
      done = 1'b0;
      tick();
      e = 8'h01 << (i % 8);
      chk("rot_gnt", gnt, e);
    end

    req = 8'h04;
    tick();
    chk("drop0_gap", gnt, 8'h00);
    tick();
    chk("g04", gnt, 8'h04);
    done = 1'b1;
    req  = 8'h82;
    tick();
    chk("g04_rel", gnt, 8'h00);
    done = 1'b0;
    tick();
    chk("skip_80", gnt, 8'h80);
    done = 1'b1;
    tick();
    chk("wrap_gap", gnt, 8'h00);
    done = 1'b0;
    tick();
    chk("wrap_02", gnt, 8'h02);

    req = 8'h83;
    tick();
    chk("nonowner_ign", gnt, 8'h02);

    req  = 8'h81;
    done = 1'b1;
    tick();
    chk("dual_rel", gnt, 8'h00);
    done = 1'b0;
    tick();
    chk("dual_next", gnt, 8'h80);
    done = 1'b1;
    tick();
    chk("w7_gap", gnt, 8'h00);
    done = 1'b0;
    tick();
    chk("w7_next01", gnt, 8'h01);

    req = 8'h10;
    tick();
    chk("pre10_gap", gnt, 8'h00);
    tick();
    chk("g10", gnt, 8'h10);
    req = 8'h00;
    tick();
    chk("drop10", gnt, 8'h00);
    done = 1'b1;
    tick();
    chk("done_gap", gnt, 8'h00);
    tick();
    chk("done_idle", gnt, 8'h00);
    done = 1'b0;

    req = 8'h20;
    tick();
    chk("g20", gnt, 8'h20);
    rst = 1'b1;
    req = 8'h21;
    tick();
    chk("midrst_gnt", gnt, 8'h00);
    chk("midrst_vld", {7'b0, vld}, 8'h00);
    rst = 1'b0;
    tick();
    chk("midrst_ptr0", gnt, 8'h01);

    req = 8'h00;
    tick();
    chk("clr_gap", gnt, 8'h00);
    tick();
    chk("clr_idle", gnt, 8'h00);
    req = 8'h08;
    tick();
    chk("hold_c0", gnt, 8'h08);
    tick();
    chk("hold_c1", gnt, 8'h08);
    tick();
    chk("hold_c2", gnt, 8'h08);
    tick();
    chk("hold_c3", gnt, 8'h08);
    chk("hold_tmo0", {7'b0, tmo}, 8'h00);
    tick();
`ifdef ARB_TIMEOUT_EN
    chk("tmo_gnt", gnt, 8'h00);
    chk("tmo_pulse", {7'b0, tmo}, 8'h01);
    tick();
    chk("tmo_regnt", gnt, 8'h08);
    chk("tmo_clr", {7'b0, tmo}, 8'h00);
`else
    chk("nohold_gnt", gnt, 8'h08);
    chk("nohold_tmo", {7'b0, tmo}, 8'h00);
    tick();
    chk("nohold_gnt2", gnt, 8'h08);
`endif

    req = 8'h00;
    tick();
    chk("end_gap", gnt, 8'h00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
